pipelined_adder: RTL
====================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit; successor to the single-cycle 32-bit adder.
//  Operand width and pipeline depth are configurable. Carry is split into STAGES equal
//  chunks, one chunk resolved per stage. Outputs carry, signed-overflow and zero flags.
//  Uses a valid/ready handshake with backpressure, for the ALU and the address/branch-target paths.
// PARAMETERS
//  WIDTH   32  operand/result width in bits
//  STAGES  4   number of pipeline stages = latency in cycles; WIDTH % STAGES must be 0
//              (elaboration $error otherwise); CHUNK = WIDTH/STAGES bits resolved per stage
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands presented this cycle
//  in_ready   out  1      unit accepts operands this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sub     in   1      0: add, 1: subtract (B inverted)
//  in_cin     in   1      carry-in; for plain A-B the caller drives 1
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result this cycle
//  out_sum    out  WIDTH  result
//  out_carry  out  1      carry out of bit WIDTH-1 (for subtract: 1 = no borrow)
//  out_ovf    out  1      signed overflow
//  out_zero   out  1      out_sum == 0
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
//  - Arithmetic: Bx = in_sub ? ~in_b : in_b.
//    {out_carry, out_sum} = in_a + Bx + in_cin, evaluated at WIDTH+1 bits.
//  - Overflow: out_ovf = (A[W-1] == Bx[W-1]) && (sum[W-1] != A[W-1]).
//  - Pipeline: stage k (0..STAGES-1) adds chunk k of A/Bx plus the carry registered by stage k-1.
//    Stage 0 uses in_cin. Unprocessed upper chunks and finished lower sum chunks are carried in
//    per-stage registers. Each stage has a valid bit.
//  - Flag timing: flags and out_zero are computed from the final-stage registers. They are valid
//    exactly when out_valid is 1.
//  - Advance: adv = !out_valid || out_ready. When adv=1, every stage shifts forward by one stage.
//    When adv=0, the whole pipe holds.
//  - Input acceptance: in_ready = adv (combinational). A transfer occurs when
//    in_valid && in_ready. A cycle with adv=1 and no transfer inserts a bubble (valid=0).
//  - Latency: an operand accepted in cycle t appears with out_valid=1 in cycle t+STAGES, if
//    out_ready stayed high. Throughput is 1 result/cycle.
//  - Output stability: while out_valid && !out_ready, out_sum/out_carry/out_ovf/out_zero are
//    held stable, and in_ready=0.
//  - Reset: when rst=1 at an edge, all valid bits are cleared, including mid-operation. In-flight
//    results are dropped and not re-issued.
//  - Reset values: out_valid=0, out_sum=0, out_carry=0, out_ovf=0, out_zero=0. While rst is
//    asserted, in_ready follows adv and is 1.
//  - Wrap-around: sums wrap modulo 2^WIDTH; no saturation.
//  - Bubbles: bubbles in the pipe are not collapsed.
//  - STAGES=1: degenerates to a single registered adder with latency 1 and identical handshake.
// TESTING (WIDTH=32, STAGES=4 unless noted)
//  1 Carry chain: A=0xFFFFFFFF, B=1, sub=0, cin=0 -> after 4 cycles sum=0x00000000, carry=1,
//    zero=1, ovf=0. Carry ripples across all 4 chunk boundaries.
//  2 Signed overflow: A=0x7FFFFFFF, B=1 add -> sum=0x80000000, ovf=1, carry=0.
//    A=0x80000000, B=1, sub=1, cin=1 -> sum=0x7FFFFFFF, ovf=1, carry=1.
//  3 Subtract with borrow: A=5, B=7, sub=1, cin=1 -> sum=0xFFFFFFFE, carry=0, ovf=0, zero=0.
//    A=B=0x1234 sub -> zero=1, carry=1.
//  4 Throughput/backpressure: 16 back-to-back random ops with out_ready=1 -> 16 results in order,
//    one per cycle from cycle 4. Drop out_ready for 3 cycles mid-stream -> in_ready=0 and outputs
//    frozen, then no loss or duplication, order preserved.
//  5 Reset mid-operation: issue 3 ops, assert rst for 1 cycle at the 2nd cycle -> out_valid=0 from
//    the next edge, none of the 3 results ever appear, and a new op issued after reset returns
//    after 4 cycles.
//  6 Parametric: WIDTH=64/STAGES=8 and WIDTH=32/STAGES=1 -> random ops match the reference model
//    {carry,sum}=A+Bx+cin, with latency equal to STAGES.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Operand/result bundle for pipelined_adder. One valid/ready pair on each side.
// A transfer on either side happens on a rising edge where valid && ready.
// A producer keeps its payload stable from the first valid cycle until that transfer.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES equal chunks, one chunk per stage.
// The whole pipe advances together, or it holds while the result waits on a stalled consumer.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              rst,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic adv;

    // Per-stage state after the stage has resolved its chunk
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  bx_q [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;

    // Stage inputs: index 0 is the operand port, index k is the register of stage k-1
    logic [WIDTH-1:0]  a_ch  [STAGES];
    logic [WIDTH-1:0]  bx_ch [STAGES];
    logic [WIDTH-1:0]  s_ch  [STAGES];
    logic [STAGES-1:0] c_ch;
    logic [STAGES-1:0] v_ch;

    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic [STAGES-1:0] nxt_c;

    always_comb begin
        logic [CHUNK:0] part;
        part     = '0;
        a_ch[0]  = bus.in_a;
        bx_ch[0] = bus.in_sub ? ~bus.in_b : bus.in_b;
        s_ch[0]  = '0;
        c_ch[0]  = bus.in_cin;
        v_ch[0]  = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_ch[k]  = a_q[k-1];
            bx_ch[k] = bx_q[k-1];
            s_ch[k]  = s_q[k-1];
            c_ch[k]  = c_q[k-1];
            v_ch[k]  = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, a_ch[k][k*CHUNK +: CHUNK]}
                 + {1'b0, bx_ch[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_ch[k]};
            nxt_s[k] = s_ch[k];
            nxt_s[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            nxt_c[k] = part[CHUNK];
        end
    end

    // A bubble entering stage 0 still loads the operand bus; its valid bit of 0 makes it harmless
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
            end
        end else if (adv) begin
            v_q <= v_ch;
            c_q <= nxt_c;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_ch[k];
                bx_q[k] <= bx_ch[k];
                s_q[k]  <= nxt_s[k];
            end
        end
    end

    assign adv          = !v_q[LAST] || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = v_q[LAST];

    // Result and flags read as zero whenever no result is presented
    assign bus.out_sum   = v_q[LAST] ? s_q[LAST] : '0;
    assign bus.out_carry = v_q[LAST] && c_q[LAST];
    assign bus.out_ovf   = v_q[LAST] && (a_q[LAST][WIDTH-1] == bx_q[LAST][WIDTH-1])
                                     && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
    assign bus.out_zero  = v_q[LAST] && (s_q[LAST] == '0);
endmodule
